// File: rtl/ld_pkg.sv
// rtl/ld_pkg.sv - shared constants, state encoding and start-check helper for the load sequencer
package ld_pkg;

  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISALIGN = 2'd1;
  localparam logic [1:0] FC_ILLEGAL  = 2'd2;
  localparam logic [1:0] FC_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2,
    ERR  = 2'd3
  } state_t;

  // Byte loads never fault on alignment; halfwords need ea[0]=0, words need ea[1:0]=0.
  function automatic logic [1:0] start_fault(input logic [2:0] f3, input logic [1:0] ea_lo);
    logic [1:0] code;
    case (f3)
      F3_LB, F3_LBU: code = FC_NONE;
      F3_LH, F3_LHU: code = ea_lo[0] ? FC_MISALIGN : FC_NONE;
      F3_LW:         code = (ea_lo != 2'b00) ? FC_MISALIGN : FC_NONE;
      default:       code = FC_ILLEGAL;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// rtl/load_align_ext.sv - selects the addressed byte/halfword lane of a read word and extends it
module load_align_ext
  import ld_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_ea_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_val
);

  logic [7:0]  w_b;
  logic [15:0] w_h;

  assign w_b = i_word[8*i_ea_lo +: 8];
  assign w_h = i_word[16*i_ea_lo[1] +: 16];

  always_comb begin
    o_val = i_word;
    case (i_funct3)
      F3_LB:   o_val = {{24{w_b[7]}}, w_b};
      F3_LH:   o_val = {{16{w_h[15]}}, w_h};
      F3_LBU:  o_val = {24'b0, w_b};
      F3_LHU:  o_val = {16'b0, w_h};
      default: o_val = i_word;
    endcase
  end

endmodule

// File: rtl/load_seq_ctrl.sv
// rtl/load_seq_ctrl.sv - RV32I load sequencer: address check, req/ack word read, lane extract, writeback
module load_seq_ctrl
  import ld_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TMO_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op,
  input  logic        flush,
  input  logic [6:0]  ins_dec_op,
  input  logic [2:0]  ins_dec_funct3,
  input  logic [31:0] reg_rs1_val,
  input  logic [31:0] ins_dec_imm,
  input  logic [4:0]  reg_rd,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        reg_w_op,
  output logic [4:0]  reg_w_reg_idx,
  output logic [31:0] reg_w_reg_val,
  output logic        fault,
  output logic [1:0]  fault_code
);

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_ea_lo;
  logic [2:0]        r_f3;
  logic [4:0]        r_rd;
  logic [1:0]        r_code, w_code_nxt;
  logic [TMO_W-1:0]  r_cnt;

  logic [31:0]       w_ea;
  logic              w_start;
  logic              w_tmo;
  logic [31:0]       w_ext;

  logic              r_mem_req, w_mem_req_nxt;
  logic [31:0]       r_mem_addr, w_mem_addr_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_reg_w_op, w_reg_w_op_nxt;
  logic [4:0]        r_idx, w_idx_nxt;
  logic [31:0]       r_val, w_val_nxt;
  logic              r_fault, w_fault_nxt;
  logic [1:0]        r_fault_code, w_fault_code_nxt;

  assign w_ea    = reg_rs1_val + ins_dec_imm;
  assign w_start = (r_state == IDLE) && op && !flush && (ins_dec_op == OPC_LOAD);
  // r_cnt counts completed REQ cycles, so the last allowed one sees TIMEOUT_CYCLES-1.
  assign w_tmo   = (r_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  load_align_ext u_align (
    .i_word   (mem_rdata),
    .i_ea_lo  (r_ea_lo),
    .i_funct3 (r_f3),
    .o_val    (w_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ea_lo      <= 2'b00;
      r_f3         <= 3'b000;
      r_rd         <= 5'd0;
      r_code       <= FC_NONE;
      r_cnt        <= '0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_reg_w_op   <= 1'b0;
      r_idx        <= 5'd0;
      r_val        <= 32'd0;
      r_fault      <= 1'b0;
      r_fault_code <= FC_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      if (w_start) begin
        r_ea_lo <= w_ea[1:0];
        r_f3    <= ins_dec_funct3;
        r_rd    <= reg_rd;
      end
      r_cnt        <= (r_state == REQ && w_state_nxt == REQ) ? r_cnt + 1'b1 : '0;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_reg_w_op   <= w_reg_w_op_nxt;
      r_idx        <= w_idx_nxt;
      r_val        <= w_val_nxt;
      r_fault      <= w_fault_nxt;
      r_fault_code <= w_fault_code_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_code_nxt  = start_fault(ins_dec_funct3, w_ea[1:0]);
          w_state_nxt = (w_code_nxt == FC_NONE) ? REQ : ERR;
        end
      end
      REQ: begin
        if (flush) begin
          w_state_nxt = IDLE;
        end else if (mem_ack) begin
          w_state_nxt = WB;
        end else if (w_tmo) begin
          w_state_nxt = ERR;
          w_code_nxt  = FC_TIMEOUT;
        end
      end
      WB:      w_state_nxt = IDLE;
      ERR:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are computed from the next state so every port comes straight from a flop.
  always_comb begin
    w_mem_req_nxt    = (w_state_nxt == REQ);
    w_mem_addr_nxt   = 32'd0;
    w_busy_nxt       = (w_state_nxt != IDLE);
    w_done_nxt       = 1'b0;
    w_reg_w_op_nxt   = 1'b0;
    w_idx_nxt        = 5'd0;
    w_val_nxt        = 32'd0;
    w_fault_nxt      = 1'b0;
    w_fault_code_nxt = FC_NONE;
    if (w_state_nxt == REQ) begin
      w_mem_addr_nxt = (r_state == IDLE) ? {w_ea[31:2], 2'b00} : r_mem_addr;
    end
    if (w_state_nxt == WB) begin
      w_done_nxt     = 1'b1;
      w_reg_w_op_nxt = (r_rd != 5'd0);
      w_idx_nxt      = r_rd;
      w_val_nxt      = w_ext;
    end
    if (w_state_nxt == ERR) begin
      w_fault_nxt      = 1'b1;
      w_fault_code_nxt = w_code_nxt;
    end
  end

  assign mem_req       = r_mem_req;
  assign mem_addr      = r_mem_addr;
  assign busy          = r_busy;
  assign done          = r_done;
  // A redirect arriving during WB must still be able to cancel the architectural write.
  assign reg_w_op      = r_reg_w_op & ~flush;
  assign reg_w_reg_idx = r_idx;
  assign reg_w_reg_val = r_val;
  assign fault         = r_fault;
  assign fault_code    = r_fault_code;

endmodule

// File: tb/tb_load_seq_ctrl.sv
// tb/tb_load_seq_ctrl.sv - scoreboard bench for load_seq_ctrl with directed load vectors
module tb_load_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        op;
  logic        flush;
  logic [6:0]  ins_dec_op;
  logic [2:0]  ins_dec_funct3;
  logic [31:0] reg_rs1_val;
  logic [31:0] ins_dec_imm;
  logic [4:0]  reg_rd;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        reg_w_op;
  logic [4:0]  reg_w_reg_idx;
  logic [31:0] reg_w_reg_val;
  logic        fault;
  logic [1:0]  fault_code;

  typedef struct {
    logic        is_fault;
    logic [1:0]  code;
    logic        w_op;
    logic [4:0]  idx;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  load_seq_ctrl #(.TIMEOUT_CYCLES(4), .TMO_W(16)) dut (
    .clk(clk), .rst(rst), .op(op), .flush(flush),
    .ins_dec_op(ins_dec_op), .ins_dec_funct3(ins_dec_funct3),
    .reg_rs1_val(reg_rs1_val), .ins_dec_imm(ins_dec_imm), .reg_rd(reg_rd),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .reg_w_op(reg_w_op), .reg_w_reg_idx(reg_w_reg_idx),
    .reg_w_reg_val(reg_w_reg_val), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wb(input logic [4:0] rd, input logic [31:0] val);
    exp_t e;
    e.is_fault = 1'b0; e.code = 2'd0; e.w_op = (rd != 5'd0); e.idx = rd; e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic push_fault(input logic [1:0] code);
    exp_t e;
    e.is_fault = 1'b1; e.code = code; e.w_op = 1'b0; e.idx = 5'd0; e.val = 32'd0;
    exp_q.push_back(e);
  endtask

  task automatic drive_op(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] imm,
                          input logic [4:0] rd);
    op = 1'b1; ins_dec_op = 7'b0000011; ins_dec_funct3 = f3;
    reg_rs1_val = rs1; ins_dec_imm = imm; reg_rd = rd;
    tick();
    op = 1'b0;
  endtask

  task automatic run_load(input string name, input logic [2:0] f3, input logic [31:0] rs1,
                          input logic [31:0] imm, input logic [4:0] rd, input int waits,
                          input logic [31:0] rdata, input logic [31:0] exp_addr,
                          input logic [31:0] exp_val);
    push_wb(rd, exp_val);
    drive_op(f3, rs1, imm, rd);
    chk({name, "_req"}, mem_req, 1);
    chk({name, "_addr"}, mem_addr, exp_addr);
    repeat (waits) tick();
    chk({name, "_req_held"}, mem_req, 1);
    chk({name, "_addr_held"}, mem_addr, exp_addr);
    mem_ack = 1'b1; mem_rdata = rdata;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    chk({name, "_done"}, done, 1);
    tick();
    chk({name, "_idle"}, busy, 0);
    chk({name, "_done_pulse"}, done, 0);
  endtask

  task automatic run_fault(input string name, input logic [2:0] f3, input logic [31:0] rs1,
                           input logic [31:0] imm, input logic [1:0] code);
    push_fault(code);
    drive_op(f3, rs1, imm, 5'd9);
    chk({name, "_no_req"}, mem_req, 0);
    chk({name, "_fault"}, fault, 1);
    tick();
    chk({name, "_idle"}, busy, 0);
    chk({name, "_fault_pulse"}, fault, 0);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst && !flush && (done || fault)) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_event", {30'd0, fault, done}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_done", done, !e.is_fault);
          chk("sb_fault", fault, e.is_fault);
          chk("sb_fault_code", fault_code, e.code);
          chk("sb_reg_w_op", reg_w_op, e.w_op);
          chk("sb_reg_idx", reg_w_reg_idx, e.idx);
          chk("sb_reg_val", reg_w_reg_val, e.val);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

  initial begin : stim
    int n_req;
    rst = 1'b1; op = 1'b0; flush = 1'b0; ins_dec_op = 7'd0; ins_dec_funct3 = 3'd0;
    reg_rs1_val = 32'd0; ins_dec_imm = 32'd0; reg_rd = 5'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (2) tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    chk("rst_reg_w_val", reg_w_reg_val, 0);
    rst = 1'b0;
    tick();

    op = 1'b1; ins_dec_op = 7'b0010011;
    tick();
    op = 1'b0;
    chk("non_load_ignored", busy, 0);

    run_load("lb",  3'd0, 32'h1000, 32'd3, 5'd5, 2, 32'h80FF_1234, 32'h1000, 32'hFFFF_FF80);
    run_load("lhu", 3'd5, 32'h2000, 32'd2, 5'd6, 0, 32'h9ABC_5678, 32'h2000, 32'h0000_9ABC);
    run_load("lh0", 3'd1, 32'h2010, 32'hFFFF_FFF2, 5'd0, 1, 32'h9ABC_5678, 32'h2000, 32'hFFFF_9ABC);
    run_load("lbu", 3'd4, 32'h2001, 32'd0, 5'd3, 3, 32'h9ABC_5678, 32'h2000, 32'h0000_0056);
    run_load("lw",  3'd2, 32'h0008, 32'd8, 5'd31, 0, 32'h1234_ABCD, 32'h0010, 32'h1234_ABCD);

    run_fault("lw_mis", 3'd2, 32'h3000, 32'd1, 2'd1);
    run_fault("lh_mis", 3'd5, 32'h3003, 32'd0, 2'd1);
    run_fault("f3_ill", 3'd3, 32'h3000, 32'd0, 2'd2);
    run_fault("f3_7",   3'd7, 32'h3000, 32'd0, 2'd2);

    push_fault(2'd3);
    drive_op(3'd2, 32'h4000, 32'd0, 5'd4);
    n_req = 0;
    for (int i = 0; i < 20; i++) begin
      if (!mem_req) break;
      n_req++;
      tick();
    end
    chk("tmo_req_cycles", n_req, 4);
    chk("tmo_busy_in_err", busy, 1);
    tick();
    chk("tmo_busy_drop", busy, 0);

    drive_op(3'd2, 32'h5000, 32'd0, 5'd8);
    tick();
    mem_ack = 1'b1; flush = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_ack = 1'b0; flush = 1'b0;
    chk("flush_ack_idle", busy, 0);
    chk("flush_ack_req", mem_req, 0);
    chk("flush_ack_no_done", done, 0);
    chk("flush_ack_no_wr", reg_w_op, 0);

    drive_op(3'd2, 32'h6000, 32'd0, 5'd10);
    op = 1'b1; ins_dec_funct3 = 3'd2; reg_rs1_val = 32'h7000; reg_rd = 5'd11;
    tick();
    op = 1'b0;
    chk("busy_op_addr", mem_addr, 32'h6000);
    mem_ack = 1'b1; mem_rdata = 32'h3333_4444;
    tick();
    mem_ack = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush_wb_no_wr", reg_w_op, 0);
    tick();
    flush = 1'b0;
    chk("flush_wb_idle", busy, 0);

    push_wb(5'd12, 32'h5555_6666);
    drive_op(3'd2, 32'h6100, 32'd0, 5'd12);
    op = 1'b1; reg_rd = 5'd13;
    tick();
    op = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h5555_6666;
    tick();
    mem_ack = 1'b0;
    tick();
    chk("busy_op_not_queued", busy, 0);

    drive_op(3'd2, 32'h8000, 32'd0, 5'd14);
    chk("rst_mid_req_before", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_req", mem_req, 0);
    chk("rst_async_busy", busy, 0);
    tick();
    rst = 1'b0;
    tick();
    run_load("post_rst", 3'd2, 32'h0000_0010, 32'd0, 5'd7, 1, 32'hDEAD_BEEF, 32'h0010, 32'hDEAD_BEEF);

    repeat (3) tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/load_seq_ctrl.md
Name: load_seq_ctrl

Overview:
Multi-cycle sequencer for RV32I LOAD instructions (opcode 7'b0000011) in the execute stage. It computes the effective address, checks alignment and funct3, runs a request/acknowledge word read on the data-memory port, then extracts and extends the addressed byte, halfword or word. It drives the register-file write port for one cycle. Misaligned, illegal and timed-out accesses are reported as faults, and no register write occurs for them.

Parameters:
TIMEOUT_CYCLES, 255, cycles REQ may wait for mem_ack before a timeout fault; legal range 1..65535
TMO_W, 16, width of the timeout counter; must satisfy 2**TMO_W > TIMEOUT_CYCLES

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
op  in  1  start strobe from issue; accepted only in IDLE
flush  in  1  synchronous abort, from pipeline redirect
ins_dec_op  in  7  decoded opcode
ins_dec_funct3  in  3  decoded funct3
reg_rs1_val  in  32  base register value
ins_dec_imm  in  32  sign-extended I-immediate
reg_rd  in  5  destination register index
mem_req  out  1  memory read request; held until acknowledged
mem_addr  out  32  word-aligned address {ea[31:2],2'b00}
mem_ack  in  1  memory acknowledge; mem_rdata is valid in the same cycle
mem_rdata  in  32  little-endian read word
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a load retires (WB state)
reg_w_op  out  1  register write enable
reg_w_reg_idx  out  5  register write index
reg_w_reg_val  out  32  register write data
fault  out  1  one-cycle pulse in the ERR state
fault_code  out  2  0 = none, 1 = misaligned, 2 = illegal funct3, 3 = timeout

Behaviour:
- All outputs are registered. Reset value of every output is 0; the state is IDLE and the counter is 0. Reset asserted mid-transaction drops mem_req asynchronously, and the pending load is discarded.
- IDLE: start when op=1, ins_dec_op=7'b0000011 and flush=0.
  - Latch reg_rd and funct3.
  - Latch ea = reg_rs1_val + ins_dec_imm, modulo 2^32, no overflow detect.
  - op with any other opcode is ignored.
- Start checks, performed in the start cycle:
  - funct3 in {3,6,7}: go to ERR with code 2.
  - funct3 = 1 or 5 with ea[0]=1: go to ERR with code 1.
  - funct3 = 2 with ea[1:0]!=0: go to ERR with code 1.
  - funct3 in {0,4} never faults on alignment.
  - Otherwise go to REQ.
- REQ:
  - mem_req=1 and mem_addr is stable while in REQ; the counter increments each cycle.
  - mem_ack=1: capture mem_rdata and go to WB.
  - Counter reaches TIMEOUT_CYCLES without ack: go to ERR with code 3, and mem_req drops.
- WB: for one cycle done=1, reg_w_op=(rd!=0), reg_w_reg_idx=rd, reg_w_reg_val set as below. Next state is IDLE.
  - Lane select: b = word[8*ea[1:0] +: 8]; h = word[16*ea[1] +: 16].
  - funct3 0: {{24{b[7]}},b}.
  - funct3 1: {{16{h[15]}},h}.
  - funct3 2: word.
  - funct3 4: {24'b0,b}.
  - funct3 5: {16'b0,h}.
- ERR: fault=1 with the stored code for one cycle, reg_w_op=0, then IDLE.
- Outside WB, reg_w_op=0, reg_w_reg_idx=0 and reg_w_reg_val=0.
- Latency: op at cycle 0 gives mem_req at cycle 1. With ack at cycle k≥1, WB occurs at cycle k+1 and the block is back in IDLE at cycle k+2, so the minimum is 3 cycles op-to-IDLE.
- Back-to-back: op is accepted again in the cycle the state returns to IDLE.
- op while busy is ignored; no queueing.
- mem_ack outside REQ is ignored.
- flush=1 in REQ or WB: return to IDLE, suppress the write, drop mem_req next cycle, no fault. flush wins over a same-cycle mem_ack or timeout. flush in ERR still pulses fault.

Decomposition:
- Package ld_pkg holds:
  - OPC_LOAD = 7'b0000011.
  - funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - State encoding IDLE/REQ/WB/ERR (2 bits).
  - fault_code constants FC_NONE, FC_MISALIGN, FC_ILLEGAL, FC_TIMEOUT.
- One combinational sub-module, load_align_ext: inputs word, ea[1:0], funct3; output 32-bit extended value. It is used in WB and is unit-testable standalone.

Test Plan:
- LB: rs1=0x1000, imm=3, rdata=0x80FF_1234, rd=5, ack after 2 waits → mem_addr=0x1000, WB writes x5=0xFFFF_FF80, done one cycle.
- LHU/LH: ea=0x2002, rdata=0x9ABC_5678 → LHU gives 0x0000_9ABC; LH gives 0xFFFF_9ABC; rd=0 → done=1, reg_w_op=0.
- Misaligned/illegal: LW ea=0x3001 → fault=1, code 1, mem_req never asserted; funct3=3 → code 2.
- Timeout: TIMEOUT_CYCLES=4, no ack → mem_req high exactly 4 cycles, then fault code 3, busy drops the cycle after.
- Flush with ack: flush and mem_ack in the same REQ cycle → no reg_w_op, no done, IDLE next cycle.
- Flush otherwise: flush in WB → write suppressed; op while busy ignored.
- Async reset: rst asserted in REQ mid-cycle → mem_req=0 immediately; after release, a fresh LW ea=0x10 with rdata=0xDEAD_BEEF writes 0xDEAD_BEEF.
